// File: rtl/id_hazard_scheduler_if.sv
// Decode-stage hazard interface: decode operand info, pipeline advance handshakes and
// the scheduler's issue/forwarding decisions. The pipeline control side is the master.
interface id_hazard_scheduler_if;
  // Decode-stage instruction
  logic       id_valid;
  logic       id_src1_en;
  logic [4:0] id_src1_addr;
  logic       id_src2_en;
  logic [4:0] id_src2_addr;
  logic       id_gr_we;
  logic [4:0] id_dest;
  logic       id_is_load;

  // Pipeline advance handshakes
  logic       exe_allow_in;
  logic       exe_to_mem_fire;
  logic       mem_to_wb_fire;
  logic       wb_retire;
  logic       flush;

  // Scheduler decisions
  logic       id_ready_go;
  logic       id_fire;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;

  modport master (
    output id_valid, id_src1_en, id_src1_addr, id_src2_en, id_src2_addr,
    output id_gr_we, id_dest, id_is_load,
    output exe_allow_in, exe_to_mem_fire, mem_to_wb_fire, wb_retire, flush,
    input  id_ready_go, id_fire, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  id_valid, id_src1_en, id_src1_addr, id_src2_en, id_src2_addr,
    input  id_gr_we, id_dest, id_is_load,
    input  exe_allow_in, exe_to_mem_fire, mem_to_wb_fire, wb_retire, flush,
    output id_ready_go, id_fire, fwd_sel1, fwd_sel2
  );
endinterface

// File: rtl/id_hazard_scheduler.sv
// Decode-stage hazard scheduler for the 5-stage LoongArch pipeline.
// Shadows the GPR writers held in EXE/MEM/WB, derives the load-use interlock
// (id_ready_go) and per-source operand forwarding selects, and counts stall cycles.
module id_hazard_scheduler #(
  parameter bit          MEM_LOAD_STALL = 1'b0,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  id_hazard_scheduler_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt
);

  // Forwarding select encoding
  localparam logic [1:0] SelRf  = 2'd0;
  localparam logic [1:0] SelExe = 2'd1;
  localparam logic [1:0] SelMem = 2'd2;
  localparam logic [1:0] SelWb  = 2'd3;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] dest;
    logic       ld;
  } slot_t;

  slot_t exe_q, exe_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A slot supplies a source only for a real, non-r0 read of the register it writes.
  function automatic logic slot_hit(input logic en, input logic [4:0] addr, input slot_t s);
    return en && (addr != 5'd0) && s.v && s.we && (s.dest == addr);
  endfunction

  logic src1_exe_hit, src1_mem_hit, src1_wb_hit;
  logic src2_exe_hit, src2_mem_hit, src2_wb_hit;
  logic src1_interlock, src2_interlock;
  logic ready_go;
  logic fire;

  // Per-source slot hit detection against the shadow pipeline.
  always_comb begin
    src1_exe_hit = slot_hit(bus.id_src1_en, bus.id_src1_addr, exe_q);
    src1_mem_hit = slot_hit(bus.id_src1_en, bus.id_src1_addr, mem_q);
    src1_wb_hit  = slot_hit(bus.id_src1_en, bus.id_src1_addr, wb_q);
    src2_exe_hit = slot_hit(bus.id_src2_en, bus.id_src2_addr, exe_q);
    src2_mem_hit = slot_hit(bus.id_src2_en, bus.id_src2_addr, mem_q);
    src2_wb_hit  = slot_hit(bus.id_src2_en, bus.id_src2_addr, wb_q);
  end

  // Load data is not available until after MEM (or after WB with a sync-read RAM).
  always_comb begin
    src1_interlock = (src1_exe_hit && exe_q.ld) ||
                     (MEM_LOAD_STALL && src1_mem_hit && mem_q.ld);
    src2_interlock = (src2_exe_hit && exe_q.ld) ||
                     (MEM_LOAD_STALL && src2_mem_hit && mem_q.ld);
    ready_go       = !(src1_interlock || src2_interlock);
    fire           = bus.id_valid && ready_go && bus.exe_allow_in;
  end

  // Youngest writer wins; selects stay valid during interlock and are ignored downstream.
  always_comb begin
    bus.fwd_sel1 = SelRf;
    if (src1_exe_hit) begin
      bus.fwd_sel1 = SelExe;
    end else if (src1_mem_hit) begin
      bus.fwd_sel1 = SelMem;
    end else if (src1_wb_hit) begin
      bus.fwd_sel1 = SelWb;
    end

    bus.fwd_sel2 = SelRf;
    if (src2_exe_hit) begin
      bus.fwd_sel2 = SelExe;
    end else if (src2_mem_hit) begin
      bus.fwd_sel2 = SelMem;
    end else if (src2_wb_hit) begin
      bus.fwd_sel2 = SelWb;
    end
  end

  assign bus.id_ready_go = ready_go;
  assign bus.id_fire     = fire;
  assign stall_cnt       = stall_cnt_q;

  // Slot advance mirrors the real pipeline handshakes; all slots read old values.
  always_comb begin
    exe_d = exe_q;
    if (bus.flush) begin
      exe_d = '0;
    end else if (fire) begin
      exe_d = '{v: 1'b1, we: bus.id_gr_we, dest: bus.id_dest, ld: bus.id_is_load};
    end else if (bus.exe_to_mem_fire) begin
      exe_d.v = 1'b0;
    end

    mem_d = mem_q;
    if (bus.flush) begin
      mem_d = '0;
    end else if (bus.exe_to_mem_fire) begin
      mem_d = exe_q;
    end else if (bus.mem_to_wb_fire) begin
      mem_d.v = 1'b0;
    end

    // WB has committed, so a flush never reaches it.
    wb_d = wb_q;
    if (bus.mem_to_wb_fire) begin
      wb_d = mem_q;
    end else if (bus.wb_retire) begin
      wb_d.v = 1'b0;
    end
  end

  // Saturating interlock-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.id_valid && !ready_go && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // The WB load flag is carried for slot uniformity; WB data is always ready.
  logic unused_wb_ld;
  assign unused_wb_ld = wb_q.ld;

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_q       <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      exe_q       <= exe_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Directed bench for id_hazard_scheduler: DUT A (MEM_LOAD_STALL=0, 32-bit counter) and
// DUT B (MEM_LOAD_STALL=1, 4-bit counter for saturation). Expected outputs are queued
// when stimulus is applied and compared when the outputs are sampled.
module tb_id_hazard_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  id_hazard_scheduler_if ifa ();
  id_hazard_scheduler_if ifb ();

  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  typedef struct packed {
    logic       valid;
    logic       s1en;
    logic [4:0] s1a;
    logic       s2en;
    logic [4:0] s2a;
    logic       we;
    logic [4:0] dest;
    logic       ld;
    logic       allow;
    logic       e2m;
    logic       m2w;
    logic       ret;
    logic       fl;
  } in_t;

  typedef struct packed {
    logic        rdy;
    logic        fire;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  val;
  } exp_t;

  in_t  in_a;
  in_t  in_b;
  obs_t obs_a;
  obs_t obs_b;
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  assign ifa.id_valid        = in_a.valid;
  assign ifa.id_src1_en      = in_a.s1en;
  assign ifa.id_src1_addr    = in_a.s1a;
  assign ifa.id_src2_en      = in_a.s2en;
  assign ifa.id_src2_addr    = in_a.s2a;
  assign ifa.id_gr_we        = in_a.we;
  assign ifa.id_dest         = in_a.dest;
  assign ifa.id_is_load      = in_a.ld;
  assign ifa.exe_allow_in    = in_a.allow;
  assign ifa.exe_to_mem_fire = in_a.e2m;
  assign ifa.mem_to_wb_fire  = in_a.m2w;
  assign ifa.wb_retire       = in_a.ret;
  assign ifa.flush           = in_a.fl;

  assign ifb.id_valid        = in_b.valid;
  assign ifb.id_src1_en      = in_b.s1en;
  assign ifb.id_src1_addr    = in_b.s1a;
  assign ifb.id_src2_en      = in_b.s2en;
  assign ifb.id_src2_addr    = in_b.s2a;
  assign ifb.id_gr_we        = in_b.we;
  assign ifb.id_dest         = in_b.dest;
  assign ifb.id_is_load      = in_b.ld;
  assign ifb.exe_allow_in    = in_b.allow;
  assign ifb.exe_to_mem_fire = in_b.e2m;
  assign ifb.mem_to_wb_fire  = in_b.m2w;
  assign ifb.wb_retire       = in_b.ret;
  assign ifb.flush           = in_b.fl;

  assign obs_a = {ifa.id_ready_go, ifa.id_fire, ifa.fwd_sel1, ifa.fwd_sel2, cnt_a};
  assign obs_b = {ifb.id_ready_go, ifb.id_fire, ifb.fwd_sel1, ifb.fwd_sel2, 28'd0, cnt_b};

  id_hazard_scheduler #(
    .MEM_LOAD_STALL(1'b0),
    .CNT_W         (32)
  ) u_dut_a (
    .clk      (clk),
    .reset    (rst_a),
    .bus      (ifa),
    .stall_cnt(cnt_a)
  );

  id_hazard_scheduler #(
    .MEM_LOAD_STALL(1'b1),
    .CNT_W         (4)
  ) u_dut_b (
    .clk      (clk),
    .reset    (rst_b),
    .bus      (ifb),
    .stall_cnt(cnt_b)
  );

  function automatic in_t mk(input logic v, input logic s1en, input logic [4:0] s1a,
                             input logic s2en, input logic [4:0] s2a, input logic we,
                             input logic [4:0] d, input logic ld, input logic al,
                             input logic e2m, input logic m2w, input logic ret,
                             input logic fl);
    return {v, s1en, s1a, s2en, s2a, we, d, ld, al, e2m, m2w, ret, fl};
  endfunction

  task automatic push(input string tag, input logic rdy, input logic fire,
                      input logic [1:0] s1, input logic [1:0] s2, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag;
    e.val = {rdy, fire, s1, s2, cnt};
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic chk(input obs_t o);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".ready_go"}, 32'(o.rdy), 32'(e.val.rdy));
      cmp({e.tag, ".fire"},     32'(o.fire), 32'(e.val.fire));
      cmp({e.tag, ".sel1"},     32'(o.s1), 32'(e.val.s1));
      cmp({e.tag, ".sel2"},     32'(o.s2), 32'(e.val.s2));
      cmp({e.tag, ".cnt"},      o.cnt, e.val.cnt);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    in_a  = '0;
    in_b  = '0;
    #2;
    // Reset state: nothing in flight, fire follows valid & allow
    in_a = mk(1, 1, 5, 1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
    push("rst_a", 1, 1, 0, 0, 0);
    push("rst_b", 1, 0, 0, 0, 0);
    #1 chk(obs_a);
    chk(obs_b);
    in_a = '0;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc();

    // Load-use interlock
    in_a = mk(1, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0); push("t1_ld_issue", 1, 1, 0, 0, 0);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 5, 1, 7, 1, 6, 0, 1, 0, 0, 0, 0); push("t1_use_stall", 0, 0, 1, 0, 0);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 5, 1, 7, 1, 6, 0, 1, 1, 0, 0, 0); push("t1_stall_cnt", 0, 0, 1, 0, 1);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 5, 1, 7, 1, 6, 0, 1, 0, 0, 0, 0); push("t1_mem_fwd", 1, 1, 2, 0, 2);
    #2 chk(obs_a); cyc();

    // ALU back-to-back
    in_a = mk(1, 1, 0, 0, 0, 1, 3, 0, 1, 1, 1, 0, 0); push("t2_addi", 1, 1, 0, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 3, 1, 3, 1, 4, 0, 1, 1, 1, 0, 0); push("t2_sub", 1, 1, 1, 1, 2);
    #2 chk(obs_a); cyc();

    // Forwarding priority with r8 in every slot
    in_a = mk(1, 0, 0, 0, 0, 1, 8, 0, 1, 1, 1, 0, 0); push("t3_w1", 1, 1, 0, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 8, 0, 0, 1, 8, 0, 1, 1, 1, 0, 0); push("t3_w2", 1, 1, 1, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 8, 0, 0, 1, 8, 0, 1, 1, 1, 0, 0); push("t3_w3", 1, 1, 1, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); push("t3_all_exe", 1, 0, 1, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); push("t3_mem", 1, 0, 2, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); push("t3_wb", 1, 0, 3, 0, 2);
    #2 chk(obs_a); cyc();

    // r0 and disabled source
    in_a = mk(1, 1, 8, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0); push("t4_r0_issue", 1, 1, 0, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 0, 1, 0, 1, 9, 1, 1, 1, 0, 0, 0); push("t4_r0_read", 1, 1, 0, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0); push("t4_src2_dis", 1, 0, 0, 0, 2);
    #2 chk(obs_a);
    in_a = mk(0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0); push("t4_src2_en", 0, 0, 0, 1, 2);
    #2 chk(obs_a); cyc();

    // Flush beats a simultaneous issue; WB survives
    in_a = mk(1, 0, 0, 0, 0, 1, 11, 0, 1, 1, 1, 0, 0); push("t5_r11", 1, 1, 0, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 9, 0, 0, 1, 5, 1, 1, 1, 1, 0, 0); push("t5_ld_r5", 1, 1, 2, 0, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 11, 1, 9, 1, 12, 1, 1, 0, 0, 0, 1); push("t5_flush", 1, 1, 2, 3, 2);
    #2 chk(obs_a); cyc();
    in_a = mk(1, 1, 5, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0); push("t5_after", 1, 0, 0, 3, 2);
    #2 chk(obs_a);
    in_a = mk(0, 1, 12, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0); push("t5_dropped", 1, 0, 0, 0, 2);
    #2 chk(obs_a);
    in_a = '0;
    cyc();

    // MEM_LOAD_STALL=1 variant: MEM load interlock, async reset mid-stall
    in_b = mk(1, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0); push("t6_ld", 1, 1, 0, 0, 0);
    #2 chk(obs_b); cyc();
    in_b = mk(1, 1, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); push("t6_exe_stall", 0, 0, 1, 0, 0);
    #2 chk(obs_b); cyc();
    in_b = mk(1, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); push("t6_mem_stall", 0, 0, 2, 0, 1);
    #2 chk(obs_b); cyc();
    push("t6_cnt2", 0, 0, 2, 0, 2);
    #2 chk(obs_b);
    #1 rst_b = 1'b1;
    push("t6_async_rst", 1, 1, 0, 0, 0);
    #1 chk(obs_b);
    in_b = '0;
    #1 rst_b = 1'b0;
    cyc();

    // Counter saturation on the 4-bit counter
    in_b = mk(1, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0); push("t6_reissue", 1, 1, 0, 0, 0);
    #2 chk(obs_b); cyc();
    for (int i = 0; i < 20; i++) begin
      in_b = mk(1, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      push($sformatf("t6_sat%0d", i), 0, 0, 1, 0, (i < 15) ? 32'(i) : 32'd15);
      #2 chk(obs_b);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
